// File: rtl/gray_window_pkg.sv
// gray_window_pkg
// Shared types and constants for the 3x3 grayscale window sequencer and the
// kernel-stage debug logic.
//   state_t    : sequencer state encoding (IDLE, ARMED, FILL, RUN)
//   KERNEL_R   : kernel radius; the window centre sits this far behind the
//                newest pixel in both directions
//   BORDER     : first x/y of a newest pixel that completes a full window
//   CX_W/CY_W  : widths of the exported centre coordinates
//   coord_w()  : counter width needed to hold positions 0..n-1
package gray_window_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ARMED = 2'd1;
  localparam state_t FILL  = 2'd2;
  localparam state_t RUN   = 2'd3;

  localparam int KERNEL_R = 1;
  localparam int BORDER   = 2;

  localparam int CX_W = 10;
  localparam int CY_W = 9;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int coord_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gray_pos_counter.sv
// gray_pos_counter
// Raster x/y position counter for an IMG_W x IMG_H frame.
//   iCLK, iRST_N : clock, asynchronous active-low reset
//   en           : advance past the pixel presented this cycle
//   clr          : the pixel presented this cycle is (0,0) of a new frame
//   pos_x/pos_y  : position of the pixel presented this cycle (0,0 while clr)
//   x_last       : stored x is the last column
//   frame_last   : stored position is the last pixel of the frame
// The flags look at the stored position only, so a caller may derive clr
// from them without forming a combinational loop.
module gray_pos_counter
  import gray_window_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = coord_w(IMG_W),
  parameter int YW    = coord_w(IMG_H)
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          en,
  input  logic          clr,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          x_last,
  output logic          frame_last
);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          y_last;

  // Wrap flags come from the stored position; the presented position is
  // forced to the origin when the caller restarts the frame on this pixel.
  always_comb begin
    x_last     = (x_q == XW'(IMG_W - 1));
    y_last     = (y_q == YW'(IMG_H - 1));
    frame_last = x_last && y_last;
    pos_x      = clr ? '0 : x_q;
    pos_y      = clr ? '0 : y_q;
  end

  // The stored position is always the position the next accepted pixel will
  // take. A restart that also accepts its pixel lands on (1,0); the last
  // column wraps to the next line and the last pixel wraps to (0,0).
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clr) begin
      x_q <= en ? XW'(1) : '0;
      y_q <= '0;
    end else if (en) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

endmodule

// File: rtl/gray_window_ctrl.sv
// gray_window_ctrl
// Frame/line sequencer for the 3x3 grayscale window datapath. Arms on
// software enable, aligns to start-of-frame, counts accepted pixels into an
// x/y raster position, gates the window clock-enable and reports
// border-qualified window validity with the window centre coordinates.
//   iCLK, iRST_N : clock, asynchronous active-low reset
//   iEN          : arm request, acted on only at frame boundaries
//   iMODE        : requested filter mode, latched at frame start
//   iSOF, iDVAL  : start-of-frame marker (qualified by iDVAL), pixel valid
//   oWIN_CE      : combinational clock-enable to window/line buffers
//   oWIN_VALID   : registered, window holds no border pixels
//   oCX, oCY     : registered centre of the valid window
//   oMODE        : filter mode in force for the current frame
//   oSOF, oEOF   : registered pulses for first/last accepted pixel
//   oBUSY        : high while a frame is being consumed (FILL/RUN)
//   oRESYNC      : registered pulse when a new SOF aborts a frame
//   oFRAME_CNT   : count of completed frames, wraps
module gray_window_ctrl
  import gray_window_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int MODE_W = 2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iEN,
  input  logic [MODE_W-1:0] iMODE,
  input  logic              iSOF,
  input  logic              iDVAL,
  output logic              oWIN_CE,
  output logic              oWIN_VALID,
  output logic [CX_W-1:0]   oCX,
  output logic [CY_W-1:0]   oCY,
  output logic [MODE_W-1:0] oMODE,
  output logic              oSOF,
  output logic              oEOF,
  output logic              oBUSY,
  output logic              oRESYNC,
  output logic [15:0]       oFRAME_CNT
);

  localparam int XW = coord_w(IMG_W);
  localparam int YW = coord_w(IMG_H);

  state_t        state;
  state_t        state_nxt;
  logic          busy;
  logic          sof_pix;
  logic          start;
  logic          eof_hit;
  logic          resync;
  logic          accept;
  logic          restart;
  logic          win_hit;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic          x_last;
  logic          frame_last;

  // Pixel qualification. A frame opens on an SOF pixel seen while armed and
  // still enabled. Inside a frame every valid pixel is accepted; an SOF there
  // aborts and restarts the frame, except on the final pixel where the
  // marker is ignored and the pixel simply closes the frame.
  always_comb begin
    busy    = (state == FILL) || (state == RUN);
    sof_pix = iDVAL && iSOF;
    start   = (state == ARMED) && iEN && sof_pix;
    eof_hit = (state == RUN) && iDVAL && frame_last;
    resync  = busy && sof_pix && !eof_hit;
    restart = start || resync;
    accept  = iDVAL && (busy || start);
    win_hit = accept && (pos_x >= XW'(BORDER)) && (pos_y >= YW'(BORDER));
  end

  gray_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_pos (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .en         (accept),
    .clr        (restart),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .x_last     (x_last),
    .frame_last (frame_last)
  );

  // Next-state logic. FILL covers the first two lines, which only prime the
  // line buffers; RUN begins once the end of line 1 is accepted. The end of
  // frame goes straight back to ARMED or IDLE so back-to-back frames lose no
  // pixel, and dropping iEN mid-frame only takes effect at that point.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (iEN) state_nxt = ARMED;
      end
      ARMED: begin
        if (!iEN)        state_nxt = IDLE;
        else if (sof_pix) state_nxt = FILL;
      end
      FILL: begin
        if (resync)
          state_nxt = FILL;
        else if (accept && x_last && (pos_y == YW'(BORDER - 1)))
          state_nxt = RUN;
      end
      RUN: begin
        if (resync)       state_nxt = FILL;
        else if (eof_hit) state_nxt = iEN ? ARMED : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_nxt;
  end

  // Registered outputs, aligned with the one-cycle window register
  // downstream. The centre lags the newest pixel by the kernel radius and
  // holds between valid windows. The mode is sampled only when a frame
  // (re)starts so mid-frame changes cannot disturb the kernel.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oWIN_VALID <= 1'b0;
      oCX        <= '0;
      oCY        <= '0;
      oMODE      <= '0;
      oSOF       <= 1'b0;
      oEOF       <= 1'b0;
      oRESYNC    <= 1'b0;
      oFRAME_CNT <= '0;
    end else begin
      oWIN_VALID <= win_hit;
      oSOF       <= restart;
      oEOF       <= eof_hit;
      oRESYNC    <= resync;
      if (win_hit) begin
        oCX <= CX_W'(pos_x - XW'(KERNEL_R));
        oCY <= CY_W'(pos_y - YW'(KERNEL_R));
      end
      if (restart) oMODE <= iMODE;
      if (eof_hit) oFRAME_CNT <= oFRAME_CNT + 16'd1;
    end
  end

  assign oWIN_CE = accept;
  assign oBUSY   = busy;

endmodule
